data_mem_responder: RTL and testbench

Responder end of the CPU data-memory interface: accepts address, write data, write enable and byte mask from the single-cycle core and returns read data in the same cycle. Contains a byte-maskable word RAM and a small MMIO block with a 64-bit cycle timer, a compare register, an interrupt line and a debug output register. Sits beside the core in the top-level SoC; the instruction port is out of scope.

---
 rtl/data_mem_responder_pkg.sv | 35 +++
 rtl/data_mem_responder_mmio_timer.sv | 68 ++++++
 rtl/data_mem_responder.sv | 117 +++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, STATUS layout,
// reset values, register-select encoding and a byte-lane merge helper.
package data_mem_responder_pkg;

    localparam logic [15:0] OFF_MTIME_LO    = 16'h0000;
    localparam logic [15:0] OFF_MTIME_HI    = 16'h0004;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h0008;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h000C;
    localparam logic [15:0] OFF_STATUS      = 16'h0010;
    localparam logic [15:0] OFF_DEBUG_OUT   = 16'h0014;

    localparam int          STATUS_MATCH_BIT = 0;
    localparam logic [63:0] MTIMECMP_RST     = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_MTIMECMP_LO,
        SEL_MTIMECMP_HI,
        SEL_STATUS,
        SEL_DEBUG_OUT
    } mmio_sel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = mask[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// 64-bit free-running timer with compare, sticky match status and level IRQ.
// Writes land on the clock edge; reads and irq_o are combinational from registers; no backpressure.
module mmio_timer
    import data_mem_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_mtime_lo_i,
    input  logic        wr_mtime_hi_i,
    input  logic        wr_cmp_lo_i,
    input  logic        wr_cmp_hi_i,
    input  logic        wr_status_i,
    input  logic [3:0]  wr_mask_i,
    input  logic [31:0] wr_data_i,
    input  mmio_sel_e   rd_sel_i,
    output logic [31:0] rd_data_o,
    output logic        irq_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        match_q, match_d;

    assign irq_o = (mtime_q >= mtimecmp_q);

    always_comb begin
        mtime_d = mtime_q + 64'd1;
        if (wr_mtime_lo_i || wr_mtime_hi_i) begin
            // A software write freezes the count for that cycle.
            mtime_d = mtime_q;
            if (wr_mtime_lo_i) mtime_d[31:0]  = byte_merge(mtime_q[31:0],  wr_data_i, wr_mask_i);
            if (wr_mtime_hi_i) mtime_d[63:32] = byte_merge(mtime_q[63:32], wr_data_i, wr_mask_i);
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo_i) mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  wr_data_i, wr_mask_i);
        if (wr_cmp_hi_i) mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wr_data_i, wr_mask_i);

        match_d = match_q;
        if (wr_status_i && wr_mask_i[0] && wr_data_i[STATUS_MATCH_BIT]) match_d = 1'b0;
        if (irq_o) match_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            match_q    <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            match_q    <= match_d;
        end
    end

    always_comb begin
        rd_data_o = 32'h0;
        case (rd_sel_i)
            SEL_MTIME_LO:    rd_data_o = mtime_q[31:0];
            SEL_MTIME_HI:    rd_data_o = mtime_q[63:32];
            SEL_MTIMECMP_LO: rd_data_o = mtimecmp_q[31:0];
            SEL_MTIMECMP_HI: rd_data_o = mtimecmp_q[63:32];
            SEL_STATUS:      rd_data_o[STATUS_MATCH_BIT] = match_q;
            default:         rd_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-maskable RAM plus MMIO timer/debug window, zero-latency reads,
// writes on the edge, never stalls. Optional sticky unmapped-access flag under DMEM_BUS_ERR_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memWr,
    input  logic [3:0]      wrMask,
    input  logic [XLEN-1:0] memAddr,
    input  logic [XLEN-1:0] memWriteData,
    output logic [XLEN-1:0] memReadData,
    output logic            timerIrq,
    output logic [XLEN-1:0] debugData,
    output logic            debugValid,
    output logic            busErr
);

    localparam int              IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * 4);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             ram_hit;
    mmio_sel_e        mmio_sel;
    logic             wr_en;
    logic             wr_debug;
    logic [31:0]      timer_rd;
    logic [31:0]      debug_data_q, debug_data_d;
    logic             debug_vld_q;

    assign ram_hit = (memAddr < RAM_BYTES);
    assign ram_idx = memAddr[IDX_W+1:2];
    // An all-zero mask is a true no-op: it must not freeze the timer or pulse debugValid.
    assign wr_en   = memWr && (|wrMask);

    always_comb begin
        mmio_sel = SEL_NONE;
        if (memAddr[31:16] == MMIO_BASE[31:16]) begin
            case (memAddr[15:0])
                OFF_MTIME_LO:    mmio_sel = SEL_MTIME_LO;
                OFF_MTIME_HI:    mmio_sel = SEL_MTIME_HI;
                OFF_MTIMECMP_LO: mmio_sel = SEL_MTIMECMP_LO;
                OFF_MTIMECMP_HI: mmio_sel = SEL_MTIMECMP_HI;
                OFF_STATUS:      mmio_sel = SEL_STATUS;
                OFF_DEBUG_OUT:   mmio_sel = SEL_DEBUG_OUT;
                default:         mmio_sel = SEL_NONE;
            endcase
        end
    end

    mmio_timer u_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .wr_mtime_lo_i (wr_en && (mmio_sel == SEL_MTIME_LO)),
        .wr_mtime_hi_i (wr_en && (mmio_sel == SEL_MTIME_HI)),
        .wr_cmp_lo_i   (wr_en && (mmio_sel == SEL_MTIMECMP_LO)),
        .wr_cmp_hi_i   (wr_en && (mmio_sel == SEL_MTIMECMP_HI)),
        .wr_status_i   (wr_en && (mmio_sel == SEL_STATUS)),
        .wr_mask_i     (wrMask),
        .wr_data_i     (memWriteData),
        .rd_sel_i      (mmio_sel),
        .rd_data_o     (timer_rd),
        .irq_o         (timerIrq)
    );

    // DEBUG_OUT and unmapped addresses read back as zero through the timer mux default.
    assign memReadData = ram_hit ? mem_q[ram_idx] : timer_rd;

    // RAM ignores reset so a write coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wrMask[i]) mem_q[ram_idx][i*8 +: 8] <= memWriteData[i*8 +: 8];
            end
        end
    end

    assign wr_debug     = wr_en && (mmio_sel == SEL_DEBUG_OUT);
    assign debug_data_d = wr_debug ? byte_merge(debug_data_q, memWriteData, wrMask) : debug_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            debug_data_q <= 32'h0;
            debug_vld_q  <= 1'b0;
        end else begin
            debug_data_q <= debug_data_d;
            debug_vld_q  <= wr_debug;
        end
    end

    assign debugData  = debug_data_q;
    assign debugValid = debug_vld_q;

`ifdef DMEM_BUS_ERR_EN
    logic mapped;
    logic bus_err_q, bus_err_d;

    // No read strobe exists, so every cycle presenting an unmapped address counts as an access.
    assign mapped    = ram_hit || (mmio_sel != SEL_NONE);
    assign bus_err_d = bus_err_q || !mapped;

    always_ff @(posedge clk) begin
        if (reset) bus_err_q <= 1'b0;
        else       bus_err_q <= bus_err_d;
    end

    assign busErr = bus_err_q;
`else
    assign busErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM, timer, compare/IRQ, debug, decode, reset.
module tb_data_mem_responder;

    localparam logic [31:0] A_MTIME_LO = 32'hFFFF_0000;
    localparam logic [31:0] A_MTIME_HI = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP_LO   = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP_HI   = 32'hFFFF_000C;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_0010;
    localparam logic [31:0] A_DEBUG    = 32'hFFFF_0014;
    localparam logic [31:0] A_RESV     = 32'hFFFF_0018;
`ifdef DMEM_BUS_ERR_EN
    localparam logic BUS_ERR_EXP = 1'b1;
`else
    localparam logic BUS_ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memWr;
    logic [3:0]  wrMask;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        timerIrq;
    logic [31:0] debugData;
    logic        debugValid;
    logic        busErr;

    int total = 0;
    int bad   = 0;

    data_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .memWr        (memWr),
        .wrMask       (wrMask),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .timerIrq     (timerIrq),
        .debugData    (debugData),
        .debugValid   (debugValid),
        .busErr       (busErr)
    );

    always #10 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1; memWr = 1'b0; wrMask = 4'h0; memAddr = 32'h0; memWriteData = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; the write lands on the following posedge and returns at the next negedge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        memAddr = addr; memWriteData = data; wrMask = mask; memWr = 1'b1;
        @(negedge clk);
        memWr = 1'b0; wrMask = 4'h0; memAddr = 32'h0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        memWr = 1'b0; memAddr = addr;
        #1;
        data = memReadData;
        memAddr = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        apply_reset();
        do_read(A_MTIME_LO, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_mtime_lo got=%h exp=%h", rd, 32'h0); end
        do_read(A_MTIME_HI, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_mtime_hi got=%h exp=%h", rd, 32'h0); end
        do_read(A_CMP_LO, rd);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        do_read(A_CMP_HI, rd);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        do_read(A_STATUS, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=%h", rd, 32'h0); end
        total++; if (timerIrq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", timerIrq); end
        total++; if (debugData !== 32'h0) begin bad++; $display("FAIL rst_dbg_data got=%h exp=0", debugData); end
        total++; if (debugValid !== 1'b0) begin bad++; $display("FAIL rst_dbg_vld got=%b exp=0", debugValid); end
        total++; if (busErr !== 1'b0) begin bad++; $display("FAIL rst_buserr got=%b exp=0", busErr); end
    endtask

    task automatic test_timer();
        logic [31:0] lo, hi;
        // Directly follows reset release: five edges give mtime=5.
        memAddr = A_MTIME_LO;
        repeat (5) @(negedge clk);
        do_read(A_MTIME_LO, lo);
        total++; if (lo !== 32'd5) begin bad++; $display("FAIL timer_count got=%0d exp=5", lo); end

        do_write(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        do_write(A_MTIME_HI, 32'h0, 4'hF);
        do_read(A_MTIME_LO, lo); do_read(A_MTIME_HI, hi);
        total++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL timer_load got=%h exp=%h", {hi, lo}, 64'h0000_0000_FFFF_FFFF); end
        @(negedge clk);
        do_read(A_MTIME_LO, lo); do_read(A_MTIME_HI, hi);
        total++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL timer_carry got=%h exp=%h", {hi, lo}, 64'h0000_0001_0000_0000); end

        do_write(A_MTIME_LO, 32'h5555_55AA, 4'b0001);
        do_read(A_MTIME_LO, lo); do_read(A_MTIME_HI, hi);
        total++; if ({hi, lo} !== 64'h0000_0001_0000_00AA) begin bad++; $display("FAIL timer_lo_lane got=%h exp=%h", {hi, lo}, 64'h0000_0001_0000_00AA); end
        do_write(A_MTIME_HI, 32'hAB00_0000, 4'b1000);
        do_read(A_MTIME_LO, lo); do_read(A_MTIME_HI, hi);
        total++; if ({hi, lo} !== 64'hAB00_0001_0000_00AA) begin bad++; $display("FAIL timer_hi_lane got=%h exp=%h", {hi, lo}, 64'hAB00_0001_0000_00AA); end
    endtask

    task automatic test_compare();
        logic [31:0] rd;
        logic        found;
        apply_reset();
        do_write(A_CMP_HI, 32'h0, 4'hF);
        do_write(A_CMP_LO, 32'd20, 4'hF);
        #1;
        total++; if (timerIrq !== 1'b0) begin bad++; $display("FAIL cmp_irq_early got=%b exp=0", timerIrq); end
        memAddr = A_MTIME_LO;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            #1;
            if (timerIrq === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL cmp_irq_timeout got=irq_low exp=irq_high");
        end else if (memReadData !== 32'd20) begin
            bad++; $display("FAIL cmp_irq_at got=%0d exp=20", memReadData);
        end
        @(negedge clk);
        do_read(A_STATUS, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cmp_status_set got=%h exp=1", rd); end
        do_write(A_STATUS, 32'h1, 4'hF);
        do_read(A_STATUS, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cmp_set_wins got=%h exp=1", rd); end
        do_write(A_CMP_HI, 32'h1, 4'hF);
        #1;
        total++; if (timerIrq !== 1'b0) begin bad++; $display("FAIL cmp_irq_drop got=%b exp=0", timerIrq); end
        do_write(A_STATUS, 32'h1, 4'b0010);
        do_read(A_STATUS, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cmp_w1c_lane got=%h exp=1", rd); end
        do_write(A_STATUS, 32'h1, 4'hF);
        do_read(A_STATUS, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cmp_w1c got=%h exp=0", rd); end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        do_write(32'h10, 32'hAABB_CCDD, 4'hF);
        do_write(32'h10, 32'h0000_1100, 4'b0010);
        do_read(32'h10, rd);
        total++; if (rd !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_mask got=%h exp=%h", rd, 32'hAABB_11DD); end
        do_write(32'h10, 32'h1234_5678, 4'h0);
        do_read(32'h10, rd);
        total++; if (rd !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_mask0 got=%h exp=%h", rd, 32'hAABB_11DD); end
        do_write(32'hFFC, 32'h0BAD_F00D, 4'hF);
        do_read(32'hFFC, rd);
        total++; if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL ram_top got=%h exp=%h", rd, 32'h0BAD_F00D); end
        do_read(32'h1000, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ram_past_end got=%h exp=0", rd); end
    endtask

    task automatic test_debug();
        logic [31:0] rd;
        do_write(A_DEBUG, 32'h0000_0041, 4'hF);
        total++; if (debugData !== 32'h41) begin bad++; $display("FAIL dbg_data got=%h exp=41", debugData); end
        total++; if (debugValid !== 1'b1) begin bad++; $display("FAIL dbg_pulse got=%b exp=1", debugValid); end
        @(negedge clk);
        total++; if (debugValid !== 1'b0) begin bad++; $display("FAIL dbg_pulse_end got=%b exp=0", debugValid); end
        do_read(A_DEBUG, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL dbg_read got=%h exp=0", rd); end
        do_write(A_DEBUG, 32'hFFFF_FF00, 4'b0010);
        total++; if (debugData !== 32'h0000_FF41) begin bad++; $display("FAIL dbg_merge got=%h exp=%h", debugData, 32'h0000_FF41); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        do_write(32'h0, 32'h1122_3344, 4'hF);
        memAddr = 32'h8000_0000;
        #1;
        total++; if (memReadData !== 32'h0) begin bad++; $display("FAIL unmap_read got=%h exp=0", memReadData); end
        @(negedge clk);
        total++; if (busErr !== BUS_ERR_EXP) begin bad++; $display("FAIL unmap_buserr got=%b exp=%b", busErr, BUS_ERR_EXP); end
        do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h0, rd);
        total++; if (rd !== 32'h1122_3344) begin bad++; $display("FAIL unmap_wr_drop got=%h exp=%h", rd, 32'h1122_3344); end
        do_write(A_RESV, 32'hDEAD_BEEF, 4'hF);
        do_read(A_RESV, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmap_resv got=%h exp=0", rd); end
        repeat (2) @(negedge clk);
        total++; if (busErr !== BUS_ERR_EXP) begin bad++; $display("FAIL unmap_sticky got=%b exp=%b", busErr, BUS_ERR_EXP); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_write(A_DEBUG, 32'h99, 4'hF);
        reset = 1'b1; memWr = 1'b1; wrMask = 4'hF; memAddr = A_MTIME_LO; memWriteData = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b0; memWr = 1'b0; wrMask = 4'h0; memAddr = 32'h0;
        do_read(A_MTIME_LO, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_mtime_lo got=%h exp=0", rd); end
        do_read(A_MTIME_HI, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_mtime_hi got=%h exp=0", rd); end
        do_read(A_CMP_LO, rd);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_cmp_lo got=%h exp=ffffffff", rd); end
        total++; if (timerIrq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", timerIrq); end
        total++; if (debugValid !== 1'b0) begin bad++; $display("FAIL mid_dbg_vld got=%b exp=0", debugValid); end
        total++; if (debugData !== 32'h0) begin bad++; $display("FAIL mid_dbg_data got=%h exp=0", debugData); end
        total++; if (busErr !== 1'b0) begin bad++; $display("FAIL mid_buserr got=%b exp=0", busErr); end
        reset = 1'b1; memWr = 1'b1; wrMask = 4'hF; memAddr = 32'h20; memWriteData = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 1'b0; memWr = 1'b0; wrMask = 4'h0; memAddr = 32'h0;
        do_read(32'h20, rd);
        total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL mid_ram_wr got=%h exp=%h", rd, 32'hCAFE_F00D); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_compare();
        test_ram();
        test_debug();
        test_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
